// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// the counter-width rule.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The counter runs 0..WIDTH-1, so clog2(WIDTH) bits suffice; keep at least one bit.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_using_half_adder.sv
// 1-bit full adder built from two half-adder stages; purely combinational.
module full_adder_using_half_adder (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum_out,
    output logic carry_out
);

    logic half_sum;
    logic half_carry_a;
    logic half_carry_b;

    assign half_sum     = a_in ^ b_in;
    assign half_carry_a = a_in & b_in;
    assign sum_out      = half_sum ^ c_in;
    assign half_carry_b = half_sum & c_in;
    assign carry_out    = half_carry_a | half_carry_b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: streams operands LSB first through a single
// full-adder cell, one bit per clock, then presents {carry_out, sum_out}.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output state_t           state_out
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Handshake: an operand set transfers on a rising edge where start_in=1 and
    // ready_out=1; start_in at any other time is dropped, never queued.
    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             cell_sum;
    logic             cell_carry;

    full_adder_using_half_adder u_cell (
        .a_in      (a_sh[0]),
        .b_in      (b_sh[0]),
        .c_in      (carry_q),
        .sum_out   (cell_sum),
        .carry_out (cell_carry)
    );

    // Sum bits enter at the MSB so the LSB-first stream lands in order.
    generate
        if (WIDTH == 1) begin : g_sum_one
            assign sum_next = cell_sum;
        end else begin : g_sum_wide
            assign sum_next = {cell_sum, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            ready_out <= 1'b1;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
            sum_out   <= '0;
            carry_out <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_sh      <= a_in;
                        b_sh      <= b_in;
                        carry_q   <= c_in;
                        cnt       <= '0;
                        state     <= SHIFT;
                        ready_out <= 1'b0;
                        busy_out  <= 1'b1;
                    end
                end
                SHIFT: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_sh  <= sum_next;
                    carry_q <= cell_carry;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        sum_out   <= sum_next;
                        carry_out <= cell_carry;
                        done_out  <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done_out  <= 1'b0;
                    busy_out  <= 1'b0;
                    ready_out <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    done_out  <= 1'b0;
                    busy_out  <= 1'b0;
                    ready_out <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 instance for the main scenarios
// plus a WIDTH=1 instance for the single-bit corner.
module tb_serial_adder_ctrl;
    import serial_adder_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry;
    state_t     state;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       c1;
    logic       ready1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       carry1;
    state_t     state1;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int done_seen = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .a_in(a), .b_in(b), .c_in(c),
        .ready_out(ready), .busy_out(busy), .done_out(done), .sum_out(sum),
        .carry_out(carry), .state_out(state)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start1), .a_in(a1), .b_in(b1), .c_in(c1),
        .ready_out(ready1), .busy_out(busy1), .done_out(done1), .sum_out(sum1),
        .carry_out(carry1), .state_out(state1)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_seen++;

    // Accept one operand set (DUT assumed ready) and wait for done; latency
    // is the number of edges after the accept edge until done_out is seen high.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          output int lat);
        a = av; b = bv; c = cv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        check_cnt++;
        if ({ready, busy, done, sum, carry} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b sum=%h cy=%b, want 1 0 0 00 0",
                     ready, busy, done, sum, carry);
        end else pass_cnt++;
        check_cnt++;
        if (state !== IDLE) $display("FAIL reset_state: got %0d want %0d", state, IDLE);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int lat;
        a = 8'h5A; b = 8'h3C; c = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'hFF; b = 8'hFF; c = 1'b1;
        check_cnt++;
        if ({ready, busy} !== 2'b01) $display("FAIL basic_accept: got rdy=%b busy=%b want 0 1", ready, busy);
        else pass_cnt++;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check_cnt++;
        if (lat !== 8) $display("FAIL basic_latency: got %0d edges want 8", lat);
        else pass_cnt++;
        check_cnt++;
        if ({carry, sum} !== 9'h096) $display("FAIL basic_sum: got %b_%h want 0_96", carry, sum);
        else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++;
        if ({ready, busy, done} !== 3'b100) $display("FAIL basic_return: got rdy=%b busy=%b done=%b want 1 0 0", ready, busy, done);
        else pass_cnt++;
    endtask

    task automatic test_carry();
        int lat;
        run_op(8'hFF, 8'h01, 1'b0, lat);
        check_cnt++;
        if ({carry, sum} !== 9'h100 || lat !== 8)
            $display("FAIL carry_ff_01: got %b_%h lat %0d want 1_00 lat 8", carry, sum, lat);
        else pass_cnt++;
        @(posedge clk); #1;
        run_op(8'hFF, 8'hFF, 1'b1, lat);
        check_cnt++;
        if ({carry, sum} !== 9'h1FF || lat !== 8)
            $display("FAIL carry_ff_ff_1: got %b_%h lat %0d want 1_ff lat 8", carry, sum, lat);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] op_a [3] = '{8'h12, 8'h80, 8'hC3};
        logic [7:0] op_b [3] = '{8'h34, 8'h80, 8'h3D};
        logic       op_c [3] = '{1'b1, 1'b0, 1'b1};
        logic [8:0] exp_r [3] = '{9'h047, 9'h100, 9'h101};
        int d0;
        int lat;
        d0 = done_seen;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = op_a[i]; b = op_b[i]; c = op_c[i];
            check_cnt++;
            if (ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", i, ready);
            else pass_cnt++;
            @(posedge clk); #1;
            lat = -1;
            for (int k = 1; k <= 20; k++) begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                c = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                if (done) begin
                    lat = k;
                    break;
                end
            end
            check_cnt++;
            if ({carry, sum} !== exp_r[i] || lat !== 8)
                $display("FAIL b2b_result_%0d: got %h lat %0d want %h lat 8", i, {carry, sum}, lat, exp_r[i]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
        check_cnt++;
        if (done_seen - d0 !== 3) $display("FAIL b2b_done_count: got %0d want 3", done_seen - d0);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int d0;
        int lat;
        a = 8'h77; b = 8'h11; c = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        d0 = done_seen;
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({ready, busy, done, sum, carry, state} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, IDLE})
            $display("FAIL midreset_outputs: got rdy=%b busy=%b done=%b sum=%h cy=%b st=%0d want 1 0 0 00 0 0",
                     ready, busy, done, sum, carry, state);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_cnt++;
        if (done_seen !== d0 || ready !== 1'b1)
            $display("FAIL midreset_no_done: got done count %0d rdy=%b want 0 1", done_seen - d0, ready);
        else pass_cnt++;
        run_op(8'h01, 8'h01, 1'b0, lat);
        check_cnt++;
        if ({carry, sum} !== 9'h002 || lat !== 8)
            $display("FAIL midreset_fresh: got %b_%h lat %0d want 0_02 lat 8", carry, sum, lat);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_width1();
        int lat;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check_cnt++;
        if ({ready1, busy1} !== 2'b01) $display("FAIL w1_accept: got rdy=%b busy=%b want 0 1", ready1, busy1);
        else pass_cnt++;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done1) begin
                lat = k;
                break;
            end
        end
        check_cnt++;
        if (lat !== 1 || {carry1, sum1} !== 2'b11)
            $display("FAIL w1_result: got %b_%b lat %0d want 1_1 lat 1", carry1, sum1, lat);
        else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++;
        if ({ready1, done1} !== 2'b10) $display("FAIL w1_return: got rdy=%b done=%b want 1 0", ready1, done1);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_mid_reset();
        test_width1();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
